// File: rtl/kiwi_wf_pkg.sv
// Shared types and defaults for the waterfall I/Q framer.
package kiwi_wf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH  = 16;

  function automatic logic [2*DEF_DATA_WIDTH-1:0] pack_qi(
    input logic [DEF_DATA_WIDTH-1:0] q,
    input logic [DEF_DATA_WIDTH-1:0] i
  );
    return {q, i};
  endfunction

endpackage

// File: rtl/kiwi_axis_skid2.sv
// Two-entry AXI-stream skid buffer carrying data plus last; the output is
// driven straight from storage so acceptance-to-valid latency is one cycle.
module kiwi_axis_skid2 #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_push,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_data [2];
  logic [1:0]       r_last;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             w_pop;

  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_valid = ~o_empty;
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr];
  assign w_pop   = o_valid & i_ready;

  // Storage, pointers and occupancy; caller only pushes when a slot frees up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data[0] <= {WIDTH{1'b0}};
      r_data[1] <= {WIDTH{1'b0}};
      r_last    <= 2'b00;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_last[r_wr_ptr] <= i_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/kiwi_wf_iq_framer.sv
// Pairs decimated I/Q samples into {Q,I} words and frames them with tlast.
// Build option KIWI_WF_FRAMER_DROP_EN: drop pairs instead of back-pressuring.
module kiwi_wf_iq_framer
  import kiwi_wf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_i_tdata,
  input  logic                    s_axis_i_tvalid,
  output logic                    s_axis_i_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_q_tdata,
  input  logic                    s_axis_q_tvalid,
  output logic                    s_axis_q_tready,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
  input  logic [CNT_WIDTH-1:0]    cfg_num_frames,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    frames_done
`ifdef KIWI_WF_FRAMER_DROP_EN
  ,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    overflow
`endif
);

  localparam int WORD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_frames_wr;
  logic [CNT_WIDTH-1:0]  r_frames_done;
  logic                  r_stop_pend;

  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_full, w_empty, w_out_last, w_out_valid, w_hs;
  logic                  w_both, w_space, w_run, w_take, w_last, w_count_end, w_ready;
  logic [CNT_WIDTH-1:0]  w_frames_nxt;

  generate
    if (DATA_WIDTH == DEF_DATA_WIDTH) begin : g_pack_pkg
      assign w_word = pack_qi(s_axis_q_tdata, s_axis_i_tdata);
    end else begin : g_pack_cat
      assign w_word = {s_axis_q_tdata, s_axis_i_tdata};
    end
  endgenerate

  // A slot is free when not full, or when the head word leaves this cycle.
  assign w_both       = s_axis_i_tvalid & s_axis_q_tvalid;
  assign w_space      = ~w_full | m_axis_tready;
  assign w_run        = (r_state == ST_RUN);
  assign w_take       = w_run & w_both & w_space;
  assign w_last       = (r_idx == r_len);
  assign w_frames_nxt = r_frames_wr + CNT_ONE;
  assign w_count_end  = (r_num != {CNT_WIDTH{1'b0}}) & (w_frames_nxt == r_num);
  assign w_hs         = w_out_valid & m_axis_tready;

  assign s_axis_i_tready = w_ready;
  assign s_axis_q_tready = w_ready;
  assign m_axis_tvalid   = w_out_valid;
  assign m_axis_tlast    = w_out_last;
  assign busy            = (r_state != ST_IDLE);
  assign frames_done     = r_frames_done;

  kiwi_axis_skid2 #(.WIDTH(WORD_WIDTH)) u_skid (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_data  (w_word),
    .i_last  (w_last),
    .i_push  (w_take),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (m_axis_tdata),
    .o_last  (w_out_last),
    .o_valid (w_out_valid),
    .i_ready (m_axis_tready)
  );

  // Control FSM: frame indexing, frame-count end and stop handling.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_len         <= {LEN_WIDTH{1'b0}};
      r_idx         <= {LEN_WIDTH{1'b0}};
      r_num         <= {CNT_WIDTH{1'b0}};
      r_frames_wr   <= {CNT_WIDTH{1'b0}};
      r_frames_done <= {CNT_WIDTH{1'b0}};
      r_stop_pend   <= 1'b0;
    end else begin
      if (w_hs && w_out_last) begin
        r_frames_done <= r_frames_done + CNT_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_len         <= cfg_frame_len;
            r_num         <= cfg_num_frames;
            r_idx         <= {LEN_WIDTH{1'b0}};
            r_frames_wr   <= {CNT_WIDTH{1'b0}};
            r_frames_done <= {CNT_WIDTH{1'b0}};
            r_stop_pend   <= 1'b0;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_take) begin
            r_idx <= w_last ? {LEN_WIDTH{1'b0}} : r_idx + LEN_ONE;
          end
          if (w_take && w_last) begin
            r_frames_wr <= w_frames_nxt;
            if (w_count_end || r_stop_pend || cfg_stop) begin
              r_state <= ST_DRAIN;
            end
          end else if (cfg_stop) begin
            // Stopping at a boundary is immediate; mid-frame waits for tlast.
            if (!w_take && (r_idx == {LEN_WIDTH{1'b0}})) begin
              r_state <= ST_DRAIN;
            end else begin
              r_stop_pend <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_stop_pend <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef KIWI_WF_FRAMER_DROP_EN
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic                 r_overflow;
  logic                 w_drop;

  assign w_ready    = (r_state == ST_IDLE) | (w_run & w_both);
  assign w_drop     = w_run & w_both & ~w_space;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

  // Saturating drop counter and sticky overflow, cleared by a new capture.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_drop_count <= {CNT_WIDTH{1'b0}};
      r_overflow   <= 1'b0;
    end else if ((r_state == ST_IDLE) && cfg_start) begin
      r_drop_count <= {CNT_WIDTH{1'b0}};
      r_overflow   <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != {CNT_WIDTH{1'b1}}) begin
        r_drop_count <= r_drop_count + CNT_ONE;
      end
    end
  end
`else
  assign w_ready = (r_state == ST_IDLE) | w_take;
`endif

endmodule

// File: tb/tb_kiwi_wf_iq_framer.sv
// Directed, table-driven bench for kiwi_wf_iq_framer.
module tb_kiwi_wf_iq_framer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] s_axis_i_tdata, s_axis_q_tdata;
  logic        s_axis_i_tvalid, s_axis_q_tvalid;
  logic        s_axis_i_tready, s_axis_q_tready;
  logic [15:0] cfg_frame_len, cfg_num_frames;
  logic        cfg_start, cfg_stop;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        busy;
  logic [15:0] frames_done;
`ifdef KIWI_WF_FRAMER_DROP_EN
  logic [15:0] drop_count;
  logic        overflow;
`endif

  kiwi_wf_iq_framer dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_i_tdata  (s_axis_i_tdata),
    .s_axis_i_tvalid (s_axis_i_tvalid),
    .s_axis_i_tready (s_axis_i_tready),
    .s_axis_q_tdata  (s_axis_q_tdata),
    .s_axis_q_tvalid (s_axis_q_tvalid),
    .s_axis_q_tready (s_axis_q_tready),
    .cfg_frame_len   (cfg_frame_len),
    .cfg_num_frames  (cfg_num_frames),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .busy            (busy),
    .frames_done     (frames_done)
`ifdef KIWI_WF_FRAMER_DROP_EN
    ,
    .drop_count      (drop_count),
    .overflow        (overflow)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t        tbl [8];
  logic [32:0] obs [$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_prev = 1'b0;
  logic [32:0] stall_word = 33'd0;
  logic        saw_full = 1'b0;
  logic        bp_done = 1'b0;
  int          ncyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor: collects handshaken words and checks stall stability.
  always @(negedge aclk) begin
    if (areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_stable", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {31'd0, 1'b1, stall_word});
      if (m_axis_tvalid && m_axis_tready) obs.push_back({m_axis_tlast, m_axis_tdata});
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tlast, m_axis_tdata};
      if (busy && s_axis_i_tvalid && s_axis_q_tvalid && !s_axis_i_tready) saw_full = 1'b1;
    end
  end

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    int n = 0;
    s_axis_i_tdata = i; s_axis_q_tdata = q;
    s_axis_i_tvalid = 1'b1; s_axis_q_tvalid = 1'b1;
    @(negedge aclk);
    while (!(s_axis_i_tready && s_axis_q_tready) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
    @(posedge aclk); #1;
    s_axis_i_tvalid = 1'b0; s_axis_q_tvalid = 1'b0;
  endtask

  task automatic start(input logic [15:0] len, input logic [15:0] num);
    cfg_frame_len = len; cfg_num_frames = num; cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic stop();
    cfg_stop = 1'b1;
    @(posedge aclk); #1;
    cfg_stop = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge aclk); #1;
      cycles++;
    end while (busy && cycles < 100);
    chk("idle_reached", {63'd0, busy}, 64'd0);
    @(posedge aclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0001, 16'h0101, 32'h0101_0001, 1'b0};
    tbl[1] = '{16'h0002, 16'h0102, 32'h0102_0002, 1'b0};
    tbl[2] = '{16'h0003, 16'h0103, 32'h0103_0003, 1'b0};
    tbl[3] = '{16'h0004, 16'h0104, 32'h0104_0004, 1'b1};
    tbl[4] = '{16'h0005, 16'h0105, 32'h0105_0005, 1'b0};
    tbl[5] = '{16'h0006, 16'h0106, 32'h0106_0006, 1'b0};
    tbl[6] = '{16'h0007, 16'h0107, 32'h0107_0007, 1'b0};
    tbl[7] = '{16'h0008, 16'h0108, 32'h0108_0008, 1'b1};

    areset = 1'b1; s_axis_i_tdata = 16'd0; s_axis_q_tdata = 16'd0;
    s_axis_i_tvalid = 1'b0; s_axis_q_tvalid = 1'b0;
    cfg_frame_len = 16'd0; cfg_num_frames = 16'd0; cfg_start = 1'b0; cfg_stop = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    chk("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_frames_done", {48'd0, frames_done}, 64'd0);
    chk("idle_tready", {62'd0, s_axis_i_tready, s_axis_q_tready}, 64'd3);
    @(posedge aclk); #1; areset = 1'b0;

    // Basic framing: len=3, two frames.
    obs.delete();
    start(16'd3, 16'd2);
    for (int k = 0; k < 8; k++) send(tbl[k].i, tbl[k].q);
    wait_idle(ncyc);
    chk("basic_busy_fall", {32'd0, ncyc}, 64'd3);
    chk("basic_count", obs.size(), 64'd8);
    for (int k = 0; k < 8; k++)
      if (k < obs.size()) chk("basic_word", {31'd0, obs[k]}, {31'd0, tbl[k].exp_last, tbl[k].exp_data});
    chk("basic_frames_done", {48'd0, frames_done}, 64'd2);
    send(16'hAAAA, 16'hBBBB);
    repeat (3) @(posedge aclk); #1;
    chk("idle_discard", obs.size(), 64'd8);

    // Backpressure: tready toggles, continuous mode, two 8-word frames then stop.
    obs.delete(); saw_full = 1'b0; bp_done = 1'b0;
    start(16'd7, 16'd0);
    fork
      begin
        for (int k = 1; k <= 16; k++) send(16'(k), 16'(16'h0200 + k));
        stop();
        wait_idle(ncyc);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge aclk); #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
    join
    m_axis_tready = 1'b1;
    chk("bp_count", obs.size(), 64'd16);
    for (int k = 1; k <= 16; k++)
      if (k <= obs.size()) chk("bp_word", {31'd0, obs[k-1]}, {31'd0, (k == 8 || k == 16), 16'(16'h0200 + k), 16'(k)});
    chk("bp_in_tready_drop", {63'd0, saw_full}, 64'd1);
    chk("bp_frames_done", {48'd0, frames_done}, 64'd2);

    // Stop mid-frame: the current 16-word frame still completes.
    obs.delete();
    start(16'd15, 16'd0);
    for (int k = 1; k <= 5; k++) send(16'(k), 16'(16'h0300 + k));
    stop();
    for (int k = 6; k <= 16; k++) send(16'(k), 16'(16'h0300 + k));
    wait_idle(ncyc);
    send(16'h0017, 16'h0317);
    repeat (3) @(posedge aclk); #1;
    chk("stop_count", obs.size(), 64'd16);
    for (int k = 1; k <= 16; k++)
      if (k <= obs.size()) chk("stop_word", {31'd0, obs[k-1]}, {31'd0, (k == 16), 16'(16'h0300 + k), 16'(k)});
    chk("stop_frames_done", {48'd0, frames_done}, 64'd1);

    // Unpaired valid: I alone is never consumed.
    obs.delete();
    start(16'd0, 16'd1);
    s_axis_i_tdata = 16'h0055; s_axis_i_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("lone_i_tready", {63'd0, s_axis_i_tready}, 64'd0);
    end
    chk("lone_no_out", obs.size(), 64'd0);
    @(posedge aclk); #1;
    s_axis_q_tdata = 16'h0066; s_axis_q_tvalid = 1'b1;
    @(negedge aclk);
    chk("pair_tready", {62'd0, s_axis_i_tready, s_axis_q_tready}, 64'd3);
    @(posedge aclk); #1;
    s_axis_i_tvalid = 1'b0; s_axis_q_tvalid = 1'b0;
    wait_idle(ncyc);
    chk("pair_count", obs.size(), 64'd1);
    if (obs.size() > 0) chk("pair_word", {31'd0, obs[0]}, {31'd0, 1'b1, 32'h0066_0055});
    chk("pair_frames_done", {48'd0, frames_done}, 64'd1);

    // Reset mid-frame.
    start(16'd3, 16'd0);
    for (int k = 1; k <= 6; k++) send(16'(k), 16'(16'h0400 + k));
    @(negedge aclk);
    chk("pre_rst_frames_done", {48'd0, frames_done}, 64'd1);
    chk("pre_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    areset = 1'b1; #1;
    chk("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_frames_done", {48'd0, frames_done}, 64'd0);
    @(posedge aclk); #1; areset = 1'b0;
    obs.delete();
    start(16'd1, 16'd1);
    send(16'h0011, 16'h0022);
    send(16'h0033, 16'h0044);
    wait_idle(ncyc);
    chk("post_rst_count", obs.size(), 64'd2);
    if (obs.size() > 1) begin
      chk("post_rst_w0", {31'd0, obs[0]}, {31'd0, 1'b0, 32'h0022_0011});
      chk("post_rst_w1", {31'd0, obs[1]}, {31'd0, 1'b1, 32'h0044_0033});
    end

`ifdef KIWI_WF_FRAMER_DROP_EN
    // Drop mode: output stalled for ten pairs, two buffer and eight drop.
    obs.delete();
    start(16'd15, 16'd0);
    m_axis_tready = 1'b0;
    for (int k = 1; k <= 10; k++) send(16'(k), 16'(16'h0500 + k));
    @(negedge aclk);
    chk("drop_count", {48'd0, drop_count}, 64'd8);
    chk("drop_overflow", {63'd0, overflow}, 64'd1);
    chk("drop_no_out", obs.size(), 64'd0);
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    stop();
    for (int k = 11; k <= 24; k++) send(16'(k), 16'(16'h0500 + k));
    wait_idle(ncyc);
    chk("drop_out_count", obs.size(), 64'd16);
    if (obs.size() == 16) begin
      chk("drop_w0", {31'd0, obs[0]}, {31'd0, 1'b0, 32'h0501_0001});
      chk("drop_w1", {31'd0, obs[1]}, {31'd0, 1'b0, 32'h0502_0002});
      chk("drop_w2", {31'd0, obs[2]}, {31'd0, 1'b0, 32'h050B_000B});
      chk("drop_w15", {31'd0, obs[15]}, {31'd0, 1'b1, 32'h0518_0018});
    end
    start(16'd0, 16'd1);
    @(negedge aclk);
    chk("drop_clr_count", {48'd0, drop_count}, 64'd0);
    chk("drop_clr_overflow", {63'd0, overflow}, 64'd0);
    @(posedge aclk); #1;
    send(16'h0001, 16'h0002);
    wait_idle(ncyc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kiwi_wf_iq_framer.md
Name: kiwi_wf_iq_framer

Overview:
- Sits directly downstream of the waterfall CIC decimator wrappers: one instance for I, one for Q.
- Joins the two 16-bit decimated streams into 32-bit {Q,I} words.
- Cuts the stream into frames of programmable length, with tlast on each frame's last word.
- Feeds the waterfall DMA/FIFO; frame capture is started and stopped by CPU control pulses.

Parameters:
- DATA_WIDTH, 16, width of each I/Q input sample
- LEN_WIDTH, 16, width of frame-length and sample-index counters
- CNT_WIDTH, 16, width of frame-count config and frame counters

Ports:
- aclk  in  1  system clock
- areset  in  1  asynchronous active-high reset
- s_axis_i_tdata  in  DATA_WIDTH  decimated I sample
- s_axis_i_tvalid  in  1  I sample valid
- s_axis_i_tready  out  1  I sample accepted
- s_axis_q_tdata  in  DATA_WIDTH  decimated Q sample
- s_axis_q_tvalid  in  1  Q sample valid
- s_axis_q_tready  out  1  Q sample accepted
- cfg_frame_len  in  LEN_WIDTH  samples per frame minus one
- cfg_num_frames  in  CNT_WIDTH  frames to capture; 0 = continuous
- cfg_start  in  1  single-cycle start pulse
- cfg_stop  in  1  single-cycle stop request
- m_axis_tdata  out  2*DATA_WIDTH  {Q,I} word
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last word of frame
- busy  out  1  state != IDLE
- frames_done  out  CNT_WIDTH  frames fully emitted since last start

Behaviour:
- Interface: one clock (aclk); reset is asynchronous and active-high (areset). Reset clears all state immediately, including mid-frame; partial frames are discarded.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, frames_done=0, both skid entries empty, state=IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - s_axis_i_tready = s_axis_q_tready = 1, so the CICs never stall; samples are discarded.
  - cfg_start latches cfg_frame_len and cfg_num_frames, clears the sample index and frames_done, then goes to RUN.
- RUN:
  - A pair is accepted only when i_tvalid & q_tvalid & buffer not full.
  - Both treadys are identical and driven by that condition; a lone valid is held and never consumed.
  - Each accepted pair is written to the 2-entry skid buffer with tlast = (index == latched len).
  - The index increments, wrapping to 0 after tlast.
  - cfg_start is ignored while RUN.
- Frame-count end: when a tlast word is written and the latched count is nonzero and frames written == count, go to DRAIN.
- cfg_stop in RUN:
  - If the index is 0 (frame boundary), go to DRAIN.
  - Otherwise set a stop-pending flag; the current frame completes, then go to DRAIN.
  - If cfg_stop coincides with a tlast write, go to DRAIN that cycle.
- DRAIN:
  - Input treadys are 0; the buffer empties to the output.
  - When the buffer is empty, go to IDLE.
  - cfg_start in DRAIN is ignored.
- Output: standard AXI-stream.
  - tdata/tlast are stable while tvalid & ~tready.
  - Latency from input acceptance to m_axis_tvalid is 1 cycle.
  - Full throughput of 1 word/cycle is sustained with tready held high.
- frames_done increments on each output handshake with tlast=1.
- Frame-length boundary: cfg_frame_len=0 gives 1-sample frames (tlast on every word).
- Buffer full & output handshake in the same cycle allows a simultaneous write (no bubble).

Optional Feature:
- Macro: KIWI_WF_FRAMER_DROP_EN.
- Defined:
  - In RUN, input treadys are driven by the pairing condition only (1 whenever both valid), so the CIC is never back-pressured.
  - A pair arriving while the buffer is full is dropped; the index does not advance.
  - drop_count (CNT_WIDTH output, saturating) increments.
  - overflow (sticky output) sets; both clear on cfg_start.
- Undefined: the buffer-full backpressure described above; drop_count/overflow ports do not exist.

Decomposition:
- Package kiwi_wf_pkg: state enum (IDLE/RUN/DRAIN), default widths, and a helper that packs {Q,I}.
- Sub-module kiwi_axis_skid2: a 2-entry AXI-stream skid buffer carrying data+last, with full/empty flags.

Test Plan:
- Basic framing:
  - Stimulus: len=3, num_frames=2, start; pairs I=1..8, Q=0x100+n; tready=1.
  - Response: 8 words {Q,I}; tlast on words 4 and 8; frames_done=2; busy falls 1-2 cycles after the last handshake.
- Backpressure:
  - Stimulus: len=7, continuous; tready toggles 1/0 each cycle.
  - Response: no word lost or duplicated; tdata stable while stalled; input treadys drop when the buffer is full.
- Stop mid-frame:
  - Stimulus: len=15; cfg_stop after sample 5.
  - Response: samples 6..16 still emitted; tlast on 16; IDLE; later pairs are consumed but not emitted.
- Unpaired valid:
  - Stimulus: i_tvalid high for 4 cycles before q_tvalid.
  - Response: no acceptance until both are valid; then exactly one word.
- Reset mid-operation:
  - Stimulus: assert areset during a frame.
  - Response: tvalid=0 and busy=0 immediately; frames_done=0; a new start begins at index 0.
- DROP_EN:
  - Stimulus: tready=0 for 10 cycles with continuous input.
  - Response: 2 words buffered; drop_count=8; overflow=1; both cleared by the next start.
